// File: rtl/score_pkg.sv
// Shared types and constants for the Tron match score sequencer.
package score_pkg;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HOLD = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // Two-digit BCD to binary, used to compare a score against WIN_SCORE.
  function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] units);
    return ({3'b000, tens} * 7'd10) + {3'b000, units};
  endfunction

endpackage

// File: rtl/score_controller_bcd2_counter.sv
// Two-digit BCD up-counter, saturating at 99, with synchronous clear.
module bcd2_counter
  import score_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [3:0] nxt_tens,
  output logic [3:0] nxt_units
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;

  // Next value: clear wins over increment; 99 holds.
  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (clr) begin
      tens_d  = 4'd0;
      units_d = 4'd0;
    end else if (inc && !(tens_q == 4'd9 && units_q == 4'd9)) begin
      if (units_q == 4'd9) begin
        units_d = 4'd0;
        tens_d  = tens_q + 4'd1;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q  <= 4'd0;
      units_q <= 4'd0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens      = tens_q;
  assign units     = units_q;
  assign nxt_tens  = tens_d;
  assign nxt_units = units_d;

endmodule

// File: rtl/score_controller.sv
// Match-level score sequencer: per-player BCD scores, post-point hold-off,
// winner detection and winner-digit blinking.
module score_controller
  import score_pkg::*;
#(
  parameter int WIN_SCORE   = 10,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p1_point,
  input  logic       p2_point,
  input  logic       new_match,
  output logic [3:0] player1_score_tens,
  output logic [3:0] player1_score_units,
  output logic [3:0] player2_score_tens,
  output logic [3:0] player2_score_units,
  output logic       match_over,
  output logic [1:0] winner,
  output logic       hold_active
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    WIN_BIN    = 7'(WIN_SCORE);

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [1:0]    winner_q, winner_d;

  logic          p1_inc, p2_inc;
  logic [3:0]    p1_tens, p1_units, p1_nxt_tens, p1_nxt_units;
  logic [3:0]    p2_tens, p2_units, p2_nxt_tens, p2_nxt_units;
  logic          p1_wins, p2_wins;

  // A score only moves on a lone point pulse in PLAY; a draw or new_match
  // leaves it alone (new_match clears instead).
  assign p1_inc = (state_q == ST_PLAY) && p1_point && !p2_point && !new_match;
  assign p2_inc = (state_q == ST_PLAY) && p2_point && !p1_point && !new_match;

  bcd2_counter u_p1 (
    .clk      (clk),
    .rst      (rst),
    .clr      (new_match),
    .inc      (p1_inc),
    .tens     (p1_tens),
    .units    (p1_units),
    .nxt_tens (p1_nxt_tens),
    .nxt_units(p1_nxt_units)
  );

  bcd2_counter u_p2 (
    .clk      (clk),
    .rst      (rst),
    .clr      (new_match),
    .inc      (p2_inc),
    .tens     (p2_tens),
    .units    (p2_units),
    .nxt_tens (p2_nxt_tens),
    .nxt_units(p2_nxt_units)
  );

  assign p1_wins = (bcd2bin(p1_nxt_tens, p1_nxt_units) == WIN_BIN);
  assign p2_wins = (bcd2bin(p2_nxt_tens, p2_nxt_units) == WIN_BIN);

  // Next-state logic for the match FSM and its hold/blink counters.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    blink_d  = blink_q;
    phase_d  = phase_q;
    winner_d = winner_q;
    if (new_match) begin
      state_d  = ST_PLAY;
      hold_d   = '0;
      blink_d  = '0;
      phase_d  = 1'b0;
      winner_d = WIN_NONE;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (p1_point && p2_point) begin
            state_d = ST_HOLD;
            hold_d  = HOLD_LOAD;
          end else if (p1_point) begin
            if (p1_wins) begin
              state_d  = ST_OVER;
              winner_d = WIN_P1;
              blink_d  = '0;
              phase_d  = 1'b0;
            end else begin
              state_d = ST_HOLD;
              hold_d  = HOLD_LOAD;
            end
          end else if (p2_point) begin
            if (p2_wins) begin
              state_d  = ST_OVER;
              winner_d = WIN_P2;
              blink_d  = '0;
              phase_d  = 1'b0;
            end else begin
              state_d = ST_HOLD;
              hold_d  = HOLD_LOAD;
            end
          end
        end
        ST_HOLD: begin
          if (hold_q == '0) begin
            state_d = ST_PLAY;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        ST_OVER: begin
          if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            phase_d = ~phase_q;
          end else begin
            blink_d = blink_q + 1'b1;
          end
        end
        default: state_d = ST_PLAY;
      endcase
    end
  end

  // FSM and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_PLAY;
      hold_q   <= '0;
      blink_q  <= '0;
      phase_q  <= 1'b0;
      winner_q <= WIN_NONE;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
      winner_q <= winner_d;
    end
  end

  // Output mux: in the blank phase of OVER only the winner's digits go dark.
  always_comb begin
    player1_score_tens  = p1_tens;
    player1_score_units = p1_units;
    player2_score_tens  = p2_tens;
    player2_score_units = p2_units;
    if (state_q == ST_OVER && phase_q) begin
      if (winner_q == WIN_P1) begin
        player1_score_tens  = BLANK_DIGIT;
        player1_score_units = BLANK_DIGIT;
      end else if (winner_q == WIN_P2) begin
        player2_score_tens  = BLANK_DIGIT;
        player2_score_units = BLANK_DIGIT;
      end
    end
  end

  assign match_over  = (state_q == ST_OVER);
  assign hold_active = (state_q == ST_HOLD);
  assign winner      = winner_q;

endmodule

// File: tb/tb_score_controller.sv
// Bench for score_controller: directed scenarios plus a randomized run
// against a behavioural match model.
module tb_score_controller;

  localparam int WIN   = 3;
  localparam int HOLD  = 2;
  localparam int BLINK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic p1_point = 1'b0, p2_point = 1'b0, new_match = 1'b0;

  logic [3:0] a_p1t, a_p1u, a_p2t, a_p2u;
  logic       a_over, a_hold;
  logic [1:0] a_win;
  logic [3:0] b_p1t, b_p1u, b_p2t, b_p2u;
  logic       b_over, b_hold;
  logic [1:0] b_win;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of DUT a (WIN_SCORE=3).
  int m_s1, m_s2, m_hold_left, m_win, m_age;
  bit m_over;

  always #5 clk = ~clk;

  score_controller #(.WIN_SCORE(WIN), .HOLD_CYCLES(HOLD), .BLINK_DIV(BLINK)) dut_a (
    .clk(clk), .rst(rst), .p1_point(p1_point), .p2_point(p2_point), .new_match(new_match),
    .player1_score_tens(a_p1t), .player1_score_units(a_p1u),
    .player2_score_tens(a_p2t), .player2_score_units(a_p2u),
    .match_over(a_over), .winner(a_win), .hold_active(a_hold)
  );

  score_controller #(.WIN_SCORE(12), .HOLD_CYCLES(HOLD), .BLINK_DIV(BLINK)) dut_b (
    .clk(clk), .rst(rst), .p1_point(p1_point), .p2_point(p2_point), .new_match(new_match),
    .player1_score_tens(b_p1t), .player1_score_units(b_p1u),
    .player2_score_tens(b_p2t), .player2_score_units(b_p2u),
    .match_over(b_over), .winner(b_win), .hold_active(b_hold)
  );

  function automatic void model_tick(input bit a, input bit b, input bit nm, input bit r);
    if (r || nm) begin
      m_s1 = 0; m_s2 = 0; m_hold_left = 0; m_win = 0; m_age = 0; m_over = 0;
    end else if (m_over) begin
      m_age++;
    end else if (m_hold_left > 0) begin
      m_hold_left--;
    end else if (a && b) begin
      m_hold_left = HOLD;
    end else if (a || b) begin
      if (a) m_s1 = (m_s1 < 99) ? m_s1 + 1 : 99;
      else   m_s2 = (m_s2 < 99) ? m_s2 + 1 : 99;
      if ((a ? m_s1 : m_s2) == WIN) begin
        m_over = 1; m_win = a ? 1 : 2; m_age = 0;
      end else begin
        m_hold_left = HOLD;
      end
    end
  endfunction

  function automatic logic [19:0] model_out();
    logic [3:0] t1, u1, t2, u2;
    bit blank;
    t1 = 4'(m_s1 / 10); u1 = 4'(m_s1 % 10);
    t2 = 4'(m_s2 / 10); u2 = 4'(m_s2 % 10);
    blank = m_over && (((m_age / BLINK) % 2) == 1);
    if (blank && m_win == 1) begin t1 = 4'hF; u1 = 4'hF; end
    if (blank && m_win == 2) begin t2 = 4'hF; u2 = 4'hF; end
    return {t1, u1, t2, u2, m_over, 2'(m_win), (m_hold_left > 0)};
  endfunction

  // One clock: drive on the falling edge, advance the model at the rising
  // edge, then settle before the caller samples.
  task automatic cyc(input bit a, input bit b, input bit nm, input bit r);
    @(negedge clk);
    p1_point = a; p2_point = b; new_match = nm; rst = r;
    @(posedge clk);
    model_tick(a, b, nm, r);
    #1;
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    n_checks++;
    if ({a_p1t, a_p1u, a_p2t, a_p2u, a_over, a_win, a_hold} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_a got %h want 00000", {a_p1t, a_p1u, a_p2t, a_p2u, a_over, a_win, a_hold});
    end
    n_checks++;
    if ({b_p1t, b_p1u, b_p2t, b_p2u, b_over, b_win, b_hold} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_b got %h want 00000", {b_p1t, b_p1u, b_p2t, b_p2u, b_over, b_win, b_hold});
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_point_hold();
    cyc(1, 0, 0, 0);
    n_checks++;
    if (a_p1u !== 4'd1 || a_hold !== 1'b1) begin
      n_fail++; $display("FAIL point_first units=%0d hold=%0b want 1/1", a_p1u, a_hold);
    end
    cyc(1, 0, 0, 0);
    n_checks++;
    if (a_p1u !== 4'd1 || a_hold !== 1'b1) begin
      n_fail++; $display("FAIL point_in_hold units=%0d hold=%0b want 1/1", a_p1u, a_hold);
    end
    cyc(0, 0, 0, 0);
    n_checks++;
    if (a_p1u !== 4'd1 || a_hold !== 1'b0) begin
      n_fail++; $display("FAIL hold_end units=%0d hold=%0b want 1/0", a_p1u, a_hold);
    end
  endtask

  task automatic test_draw();
    cyc(0, 0, 1, 0);
    cyc(1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({a_p1t, a_p1u, a_p2t, a_p2u} !== 16'h0 || a_hold !== (k < 2)) begin
        n_fail++;
        $display("FAIL draw k=%0d scores=%h hold=%0b want 0000/%0b", k, {a_p1t, a_p1u, a_p2t, a_p2u}, a_hold, k < 2);
      end
      cyc(0, 0, 0, 0);
    end
  endtask

  task automatic test_p2_win();
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      if (i < 2) begin cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); end
    end
    n_checks++;
    if (a_over !== 1'b1 || a_win !== 2'b10) begin
      n_fail++; $display("FAIL p2_win over=%0b winner=%b want 1/10", a_over, a_win);
    end
    for (int k = 0; k < 16; k++) begin
      logic [7:0] want2;
      want2 = (((k / BLINK) % 2) == 1) ? 8'hFF : 8'h03;
      n_checks++;
      if ({a_p2t, a_p2u} !== want2 || {a_p1t, a_p1u} !== 8'h00 || a_over !== 1'b1) begin
        n_fail++;
        $display("FAIL blink k=%0d p2=%h p1=%h over=%0b want %h/00/1", k, {a_p2t, a_p2u}, {a_p1t, a_p1u}, a_over, want2);
      end
      cyc(1, 0, 0, 0);
    end
  endtask

  task automatic test_wrap();
    cyc(0, 0, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      cyc(1, 0, 0, 0);
      n_checks++;
      if (b_p1t !== 4'(i / 10) || b_p1u !== 4'(i % 10) || b_over !== (i == 12) ||
          b_win !== ((i == 12) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL wrap i=%0d got %0d%0d over=%0b win=%b want %0d%0d", i, b_p1t, b_p1u, b_over, b_win, i / 10, i % 10);
      end
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
  endtask

  task automatic test_nm_priority();
    n_checks++;
    if (a_over !== 1'b1 || b_over !== 1'b1) begin
      n_fail++; $display("FAIL nm_pre over a=%0b b=%0b want 1/1", a_over, b_over);
    end
    cyc(1, 0, 1, 0);
    n_checks++;
    if ({a_p1t, a_p1u, a_p2t, a_p2u, a_over, a_win, a_hold} !== 20'h0 ||
        {b_p1t, b_p1u, b_p2t, b_p2u, b_over, b_win, b_hold} !== 20'h0) begin
      n_fail++;
      $display("FAIL nm_priority a=%h b=%h want 00000", {a_p1t, a_p1u, a_p2t, a_p2u, a_over, a_win, a_hold},
               {b_p1t, b_p1u, b_p2t, b_p2u, b_over, b_win, b_hold});
    end
    cyc(1, 0, 0, 0);
    n_checks++;
    if (a_p1u !== 4'd1 || a_hold !== 1'b1) begin
      n_fail++; $display("FAIL nm_then_play units=%0d hold=%0b want 1/1", a_p1u, a_hold);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      logic [19:0] got, want;
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 59) == 0, $urandom_range(0, 99) == 0);
      got  = {a_p1t, a_p1u, a_p2t, a_p2u, a_over, a_win, a_hold};
      want = model_out();
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL random k=%0d got %h want %h", k, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_point_hold();
    test_draw();
    test_p2_win();
    test_wrap();
    test_nm_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_controller.md
# score_controller

Match-level score sequencer for the two-player Tron game. Counts round wins per player in two-digit BCD and enforces a post-point hold-off. Detects the match winner and blinks the winner's digits. Its four BCD digit outputs drive the existing seven-segment multiplexed display directly; code 4'hF is the blank code, which the display decodes as all segments off.

## Interface
Parameters:
- WIN_SCORE, 10: decimal points needed to win the match; legal range 1..99.
- HOLD_CYCLES, 50_000_000: cycles after a scored point during which further point pulses are ignored; must be at least 1.
- BLINK_DIV, 25_000_000: winner-blink half-period in cycles; must be at least 1.

Ports:
- clk, in, 1: system clock; the block is single-clock.
- rst, in, 1: synchronous, active-high reset.
- p1_point, in, 1: single-cycle pulse; player 1 wins a round.
- p2_point, in, 1: single-cycle pulse; player 2 wins a round.
- new_match, in, 1: single-cycle pulse; clear the scores and start play.
- player1_score_tens, out, 4: BCD digit, or 4'hF when blanked.
- player1_score_units, out, 4: BCD digit, or 4'hF when blanked.
- player2_score_tens, out, 4: BCD digit, or 4'hF when blanked.
- player2_score_units, out, 4: BCD digit, or 4'hF when blanked.
- match_over, out, 1: high while in OVER.
- winner, out, 2: 2'b00 none, 2'b01 player 1, 2'b10 player 2.
- hold_active, out, 1: high while in HOLD; the game engine uses it to freeze the arena.

## Operation
- States are PLAY, HOLD and OVER. Reset enters PLAY.
- Reset values: all score digits 0, match_over 0, winner 00, hold_active 0, hold and blink counters 0.
- PLAY, exactly one of p1_point/p2_point high:
  - Increment that player's score by 1 in BCD; units 9 wraps to 0 with tens+1.
  - Score 99 saturates at 99.
  - If the new score equals WIN_SCORE: go to OVER and set winner to that player.
  - Otherwise go to HOLD and load the hold counter with HOLD_CYCLES-1.
- PLAY, both point pulses high in the same cycle: the round is a draw (head-on crash).
  - Neither score changes.
  - Go to HOLD anyway.
- HOLD:
  - Point pulses are ignored.
  - The counter decrements each cycle; at 0 return to PLAY.
  - HOLD lasts exactly HOLD_CYCLES cycles.
- OVER:
  - Point pulses are ignored.
  - The blink counter counts 0..BLINK_DIV-1 and then wraps; a blink phase bit toggles at each wrap.
  - Phase 0: all digits show the scores.
  - Phase 1: the winner's two digits output 4'hF; the loser's digits stay steady.
- new_match in any state, in the cycle it is high:
  - Clear both scores, winner, blink counter, blink phase and hold counter.
  - Go to PLAY.
  - new_match takes priority over point pulses asserted in the same cycle.
- Only the OVER blink path produces 4'hF. Stored score digits are always 0..9.

## Timing
- Point pulse sampled at edge N: the score outputs change after edge N.
  - Visible from cycle N+1; one-cycle latency.
- Win at edge N: match_over=1 and winner are valid from cycle N+1.
  - Blink phase 0 lasts cycles N+1..N+BLINK_DIV.
  - Winner digits are blank from N+BLINK_DIV+1.
- Non-winning point at edge N: hold_active=1 for cycles N+1..N+HOLD_CYCLES.
  - PLAY resumes at N+HOLD_CYCLES+1.
  - A point pulse in that cycle is counted.
- Reset or new_match at edge N: all outputs are at their reset values from cycle N+1.
  - Reset also takes effect mid-HOLD and mid-blink.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package score_pkg holds:
  - the state enum (PLAY, HOLD, OVER);
  - the BLANK_DIGIT = 4'hF constant;
  - the winner encodings WIN_NONE, WIN_P1 and WIN_P2;
  - a function that converts a two-digit BCD value to binary for the WIN_SCORE comparison. Alternatively, WIN_SCORE is split into tens and units at elaboration.
- Sub-module bcd2_counter, instantiated once per player:
  - inputs clk, rst, clr, inc;
  - outputs tens and units, 4 bits each;
  - saturates at 99;
  - the next value is also exposed combinationally for win detection.
- The FSM, hold counter, blink counter and output blanking live in the top level.

## Test plan
Benches use WIN_SCORE=3, HOLD_CYCLES=2, BLINK_DIV=4 unless noted.
- rst for 2 cycles -> all digits 0, match_over=0, winner=00, hold_active=0.
- p1_point pulse -> player1_score_units=1 at the next cycle; hold_active=1 for exactly 2 cycles. A p1_point during hold is ignored, so the score stays 1.
- p1_point and p2_point in the same cycle -> both scores stay 0; hold_active=1 for 2 cycles.
- Player 2 scores 3 times, each pulse after hold ends -> score 0/3, match_over=1, winner=10. Player 2's digits show 0,3 for 4 cycles, then F,F for 4 cycles, repeating; player 1's digits stay steady.
- WIN_SCORE=12: 12 spaced p1_point pulses -> units 9 wraps to tens=1/units=0 on the 10th point; win fires at 1/2.
- In OVER, new_match together with p1_point -> scores 0/0, winner=00, state PLAY. The p1_point is not counted.
